sha256_round_engine: RTL and testbench
======================================

// Module: sha256_round_engine
// PURPOSE
//  SHA-256 compression core: the consumer side of the message-expansion W stream.
//  Accepts a 512-bit block and forwards it to expansion with a start pulse.
//  Consumes W0..W63 in order, runs one compression round per accepted word,
//  and folds the result into the chaining hash to produce a 256-bit digest.
// PARAMETERS
//  NUM_ROUNDS   64   rounds per block; only 64 is legal, kept for the bench's round-count checks
// PORTS
//  clk           in   1    rising-edge clock
//  rst_n         in   1    asynchronous active-low reset
//  start         in   1    block request; accepted only while ready=1
//  first         in   1    sampled with start; 1 = H from IV, 0 = H from previous digest
//  block         in   512  message block, sampled with start
//  ready         out  1    idle, able to accept start
//  exp_m         out  512  registered copy of block, driven to expansion
//  exp_start     out  1    one-cycle pulse to expansion
//  exp_w_rdy     in   1    exp_w is valid this cycle
//  exp_w         in   32   next schedule word W[t]
//  digest_valid  out  1    one-cycle pulse; digest is valid
//  digest        out  256  H0..H7, H0 in [255:224]; holds until the next digest_valid
// BEHAVIOUR
//  Reset values
//  - ready=1; exp_start=0; digest_valid=0.
//  - exp_m=0; digest=IV (6a09e667 ... 5be0cd19).
//  - a..h=0; round counter t=0; state IDLE.
//  States
//  - IDLE: start&&ready -> latch block into exp_m and first; ready=0; go LOAD.
//  - LOAD (1 cycle): exp_start=1.
//    - a..h <= IV if first, else a..h <= digest.
//    - Hsave <= the same value.
//    - t=0; go ROUND.
//  - ROUND: each cycle with exp_w_rdy=1, perform one round with W[t] and K[t].
//    - T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]
//    - T2 = S0(a) + Maj(a,b,c)
//    - Register update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
//    - Then t<=t+1.
//    - exp_w_rdy=0: stall; a..h and t hold.
//    - Word consumed at t=NUM_ROUNDS-1 -> go FINAL.
//  - FINAL (1 cycle): digest[i] <= Hsave[i] + reg[i] for each 32-bit word; digest_valid=1.
//    - Then IDLE with ready=1.
//  Arithmetic
//  - All additions are mod 2^32; carries are discarded.
//  - K[0..63] is an internal constant ROM, FIPS 180-4 values.
//  Latency
//  - start accepted at cycle 0 -> exp_start at cycle 1.
//  - With no stalls, W0 is consumed at cycle 2 at the earliest.
//  - digest_valid comes 1 cycle after W63 is consumed.
//  Boundary conditions
//  - start while ready=0: ignored; no second exp_start is issued.
//  - exp_w_rdy during IDLE, LOAD or FINAL: ignored; t does not move.
//  - t is 6 bits and saturates at 63; it never wraps within a block.
//  - start in the same cycle as digest_valid: ignored, since ready is still 0.
//    The earliest new start is 1 cycle after digest_valid.
//  - first=0: chains from the last digest. If no digest has been produced since
//    reset, that value is the IV.
//  - rst_n low at any time:
//    - all state returns to reset values at once, with no digest_valid;
//    - a block in flight is discarded;
//    - the first start after rst_n rises is a normal start.
// TESTING
//  - "abc" padded, first=1, exp_w_rdy=1 continuously ->
//    digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
//    digest_valid 66 cycles after start.
//  - 448-bit "abcdbcdecdefdefg...nopq", block 1 with first=1, then block 2 with first=0 ->
//    final digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  - "abc" with exp_w_rdy toggling 1,0,0 repeatedly ->
//    same digest as the first test; digest_valid delayed by exactly the number of stall cycles.
//  - start pulses while busy, plus start in the digest_valid cycle ->
//    exactly one exp_start per accepted block; the digest is unchanged.
//  - rst_n pulsed low at round 30 ->
//    outputs go to reset values asynchronously with no digest_valid;
//    an "abc" block rerun afterwards gives the correct digest.
//  - first=0 as the first block after reset, on "abc" ->
//    digest equals the first=1 result.

Source files
------------

// File: rtl/sha256_round_engine_if.sv
// Block request, expansion hand-off and digest signals for the SHA-256 round engine.
// The slave modport is the engine; master is the host plus the message-expansion unit.
interface sha256_round_engine_if;
  logic         start;
  logic         first;
  logic [511:0] block;
  logic         ready;
  logic [511:0] exp_m;
  logic         exp_start;
  logic         exp_w_rdy;
  logic [31:0]  exp_w;
  logic         digest_valid;
  logic [255:0] digest;

  modport master (
    output start, first, block, exp_w_rdy, exp_w,
    input  ready, exp_m, exp_start, digest_valid, digest
  );

  modport slave (
    input  start, first, block, exp_w_rdy, exp_w,
    output ready, exp_m, exp_start, digest_valid, digest
  );
endinterface

// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: consumes the W stream from message expansion, one round per
// accepted word, and folds the working variables into the chaining hash.
module sha256_round_engine #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  sha256_round_engine_if.slave bus
);

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [5:0] T_LAST = 6'(NUM_ROUNDS - 1);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

  state_t       state, state_nxt;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  t1, t2;
  logic [255:0] hsave, digest_q, init, sum;
  logic [511:0] exp_m_q;
  logic         first_q;
  logic [5:0]   t;

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  always_comb begin
    t1   = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[t] + bus.exp_w;
    t2   = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    init = first_q ? IV : digest_q;
    sum  = {hsave[255:224] + a, hsave[223:192] + b, hsave[191:160] + c, hsave[159:128] + d,
            hsave[127:96]  + e, hsave[95:64]    + f, hsave[63:32]    + g, hsave[31:0]     + h};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = LOAD;
      LOAD:  state_nxt = ROUND;
      ROUND: if (bus.exp_w_rdy && t == T_LAST) state_nxt = FINAL;
      FINAL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The digest is presented combinationally during FINAL so it is valid alongside
  // digest_valid; the registered copy takes over from the next cycle.
  always_comb begin
    bus.ready        = (state == IDLE);
    bus.exp_start    = (state == LOAD);
    bus.digest_valid = (state == FINAL);
    bus.digest       = (state == FINAL) ? sum : digest_q;
    bus.exp_m        = exp_m_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_m_q  <= '0;
      first_q  <= 1'b0;
      {a, b, c, d, e, f, g, h} <= '0;
      hsave    <= '0;
      digest_q <= IV;
      t        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_m_q <= bus.block;
            first_q <= bus.first;
          end
        end
        LOAD: begin
          {a, b, c, d, e, f, g, h} <= init;
          hsave <= init;
          t     <= '0;
        end
        ROUND: begin
          if (bus.exp_w_rdy) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            if (t != T_LAST) t <= t + 6'd1;
          end
        end
        FINAL: digest_q <= sum;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine: plays the host and the message-expansion unit,
// checking digests against known SHA-256 answers and the handshake timing.
module tb_sha256_round_engine;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] M_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] M_TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M_TWO2 = {480'h0, 32'h000001c0};

  logic        clk = 1'b0;
  logic        rst_n;
  int          ntotal = 0;
  int          npass  = 0;
  int          nfail  = 0;
  logic [31:0] wsched [64];

  sha256_round_engine_if bus ();

  sha256_round_engine #(.NUM_ROUNDS(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chkv(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference message schedule, standing in for the expansion unit.
  task automatic expand(input logic [511:0] m);
    for (int i = 0; i < 16; i++) wsched[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      wsched[i] = (ror(wsched[i-2], 17) ^ ror(wsched[i-2], 19) ^ (wsched[i-2] >> 10))
                + wsched[i-7]
                + (ror(wsched[i-15], 7) ^ ror(wsched[i-15], 18) ^ (wsched[i-15] >> 3))
                + wsched[i-16];
  endtask

  // One block: start, feed W (optionally stalled 1,0,0), optionally reset after rst_at words.
  task automatic run_block(input logic [511:0] blk, input logic frst, input bit stall,
                           input int rst_at, output logic [255:0] dig, output int lat);
    int idx, n, k, starts;
    bit seen, offer;
    expand(blk);
    dig = '0;
    lat = -1;
    chkb("idle_ready", bus.ready, 1'b1);
    bus.start = 1'b1; bus.first = frst; bus.block = blk; bus.exp_w_rdy = 1'b0;
    @(posedge clk); #1;
    n = 1;
    bus.start = 1'b0; bus.first = ~frst; bus.block = ~blk;
    chkb("exp_start", bus.exp_start, 1'b1);
    chkb("load_ready", bus.ready, 1'b0);
    chkv("exp_m", bus.exp_m, blk);
    starts = 1; idx = 0; k = 0; seen = 1'b0;
    bus.exp_w_rdy = 1'b1; bus.exp_w = 32'hdeadbeef;
    offer = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (offer) idx++;
      if (bus.exp_start) starts++;
      if (rst_at >= 0 && idx == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chkb("rst_ready", bus.ready, 1'b1);
        chkb("rst_exp_start", bus.exp_start, 1'b0);
        chkb("rst_dv", bus.digest_valid, 1'b0);
        chkv("rst_exp_m", bus.exp_m, '0);
        chkv("rst_digest", 512'(bus.digest), 512'(IV));
        bus.start = 1'b0; bus.exp_w_rdy = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
          chkb("rst_no_dv", bus.digest_valid, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (bus.digest_valid) begin
        seen = 1'b1;
        lat  = n;
        dig  = bus.digest;
      end else begin
        bus.start = (n % 7 == 0);
        if (idx < 64) begin
          offer = stall ? (k % 3 == 0) : 1'b1;
          k++;
          bus.exp_w_rdy = offer;
          bus.exp_w = offer ? wsched[idx] : 32'h0badf00d;
        end else begin
          offer = 1'b0;
          bus.exp_w_rdy = 1'b1;
          bus.exp_w = 32'hfeedface;
        end
      end
    end
    chkb("dv_seen", seen, 1'b1);
    chkv("one_exp_start", 512'(starts), 512'd1);
    if (seen) begin
      chkb("dv_ready", bus.ready, 1'b0);
      bus.start = 1'b1; bus.first = 1'b1; bus.block = blk;
      @(posedge clk); #1;
      chkb("dv_start_ignored", bus.exp_start, 1'b0);
      chkb("post_ready", bus.ready, 1'b1);
      chkb("post_dv", bus.digest_valid, 1'b0);
      chkv("digest_hold", 512'(bus.digest), 512'(dig));
      bus.start = 1'b0;
      @(posedge clk); #1;
      chkb("idle_w_ignored", bus.exp_start, 1'b0);
      bus.exp_w_rdy = 1'b0;
    end
  endtask

  initial begin
    logic [255:0] dig;
    int lat;
    bus.start = 1'b0; bus.first = 1'b0; bus.block = '0;
    bus.exp_w_rdy = 1'b0; bus.exp_w = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chkb("reset_ready", bus.ready, 1'b1);
    chkb("reset_exp_start", bus.exp_start, 1'b0);
    chkb("reset_dv", bus.digest_valid, 1'b0);
    chkv("reset_exp_m", bus.exp_m, '0);
    chkv("reset_digest", 512'(bus.digest), 512'(IV));
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run_block(M_ABC, 1'b1, 1'b0, -1, dig, lat);
    chkv("abc_digest", 512'(dig), 512'(D_ABC));
    chkv("abc_latency", 512'(lat), 512'd66);

    run_block(M_TWO1, 1'b1, 1'b0, -1, dig, lat);
    chkv("two_blk1_latency", 512'(lat), 512'd66);
    run_block(M_TWO2, 1'b0, 1'b0, -1, dig, lat);
    chkv("two_digest", 512'(dig), 512'(D_TWO));

    run_block(M_ABC, 1'b1, 1'b1, -1, dig, lat);
    chkv("stall_digest", 512'(dig), 512'(D_ABC));
    chkv("stall_latency", 512'(lat), 512'd192);

    run_block(M_ABC, 1'b1, 1'b0, 30, dig, lat);
    run_block(M_ABC, 1'b0, 1'b0, -1, dig, lat);
    chkv("post_rst_first0_digest", 512'(dig), 512'(D_ABC));
    chkv("post_rst_latency", 512'(lat), 512'd66);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
